// File: rtl/ctrl_pkg.sv
// Shared MIPS control definitions: opcode/funct encodings, ALUOp codes and
// the packed control bundle carried from ID into EX.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LH     = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_MUL = 6'b011000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_MUL  = 4'b1001;
  localparam logic [3:0] ALU_BGEZ = 4'b1010;
  localparam logic [3:0] ALU_BEQ  = 4'b1011;
  localparam logic [3:0] ALU_BNE  = 4'b1100;
  localparam logic [3:0] ALU_BGTZ = 4'b1101;
  localparam logic [3:0] ALU_BLEZ = 4'b1110;
  localparam logic [3:0] ALU_BLTZ = 4'b1111;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic       jumpreg;
    logic       link;
    logic [3:0] aluop;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam ctrl_t BUBBLE = '{regdst: 1'b0, alusrc: 1'b0, memtoreg: 1'b0,
                               regwrite: 1'b0, memread: 1'b0, memwrite: 1'b0,
                               branch: 1'b0, jump: 1'b0, jumpreg: 1'b0,
                               link: 1'b0, aluop: ALU_ADD};

endpackage

// File: rtl/control_decoder.sv
// Purely combinational instruction-to-control-bundle decoder; anything it
// does not recognise becomes a bubble.
module control_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0]       Instr,
  output logic [CTRL_W-1:0] Ctrl
);

  ctrl_t      w_ctrl;
  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic [4:0] w_rt;
  logic       w_unused;

  assign w_op     = Instr[31:26];
  assign w_fn     = Instr[5:0];
  assign w_rt     = Instr[20:16];
  assign w_unused = ^{Instr[25:21], Instr[15:6]};
  assign Ctrl     = w_ctrl;

  always_comb begin
    w_ctrl = BUBBLE;
    case (w_op)
      OP_RTYPE: begin
        w_ctrl.regdst   = 1'b1;
        w_ctrl.regwrite = 1'b1;
        case (w_fn)
          FN_ADD: w_ctrl.aluop = ALU_ADD;
          FN_SUB: w_ctrl.aluop = ALU_SUB;
          FN_MUL: w_ctrl.aluop = ALU_MUL;
          FN_AND: w_ctrl.aluop = ALU_AND;
          FN_OR:  w_ctrl.aluop = ALU_OR;
          FN_NOR: w_ctrl.aluop = ALU_NOR;
          FN_XOR: w_ctrl.aluop = ALU_XOR;
          FN_SLL: w_ctrl.aluop = ALU_SLL;
          FN_SRL: w_ctrl.aluop = ALU_SRL;
          FN_SLT: w_ctrl.aluop = ALU_SLT;
          FN_JR: begin
            w_ctrl         = BUBBLE;
            w_ctrl.jump    = 1'b1;
            w_ctrl.jumpreg = 1'b1;
          end
          default: w_ctrl = BUBBLE;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_XORI: begin
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.regwrite = 1'b1;
        case (w_op)
          OP_ANDI: w_ctrl.aluop = ALU_AND;
          OP_ORI:  w_ctrl.aluop = ALU_OR;
          OP_SLTI: w_ctrl.aluop = ALU_SLT;
          OP_XORI: w_ctrl.aluop = ALU_XOR;
          default: w_ctrl.aluop = ALU_ADD;
        endcase
      end
      OP_LW, OP_LH, OP_LB: begin
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.memread  = 1'b1;
        w_ctrl.memtoreg = 1'b1;
        w_ctrl.regwrite = 1'b1;
      end
      OP_SW, OP_SH, OP_SB: begin
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.memwrite = 1'b1;
      end
      OP_BEQ:  begin w_ctrl.branch = 1'b1; w_ctrl.aluop = ALU_BEQ;  end
      OP_BNE:  begin w_ctrl.branch = 1'b1; w_ctrl.aluop = ALU_BNE;  end
      OP_BGTZ: begin w_ctrl.branch = 1'b1; w_ctrl.aluop = ALU_BGTZ; end
      OP_BLEZ: begin w_ctrl.branch = 1'b1; w_ctrl.aluop = ALU_BLEZ; end
      OP_REGIMM: begin
        if (w_rt == RT_BGEZ) begin
          w_ctrl.branch = 1'b1;
          w_ctrl.aluop  = ALU_BGEZ;
        end else if (w_rt == RT_BLTZ) begin
          w_ctrl.branch = 1'b1;
          w_ctrl.aluop  = ALU_BLTZ;
        end
      end
      OP_J: w_ctrl.jump = 1'b1;
      OP_JAL: begin
        w_ctrl.jump     = 1'b1;
        w_ctrl.link     = 1'b1;
        w_ctrl.regwrite = 1'b1;
      end
      default: w_ctrl = BUBBLE;
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// ID-stage control: decodes IF/ID, owns the ID/EX control register and
// resolves multiply hold, EX flush and load-use stall in that priority.
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 4,
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [31:0]        Instr_ID,
  input  logic               BranchTaken_EX,
  output logic               PCWrite,
  output logic               IFIDWrite,
  output logic               IFIDFlush,
  output logic               RegDst_EX,
  output logic               ALUSrc_EX,
  output logic               MemToReg_EX,
  output logic               RegWrite_EX,
  output logic               MemRead_EX,
  output logic               MemWrite_EX,
  output logic               Branch_EX,
  output logic               Jump_EX,
  output logic               JumpRegister_EX,
  output logic               Link_EX,
  output logic [ALUOP_W-1:0] ALUOp_EX,
  output logic [4:0]         Rt_EX,
  output logic               MulBusy
);

  ctrl_t             r_idex;
  logic [4:0]        r_rt_ex;
  logic [CNT_W-1:0]  r_mul_cnt;

  logic [CTRL_W-1:0] w_dec_bits;
  ctrl_t             w_dec;
  logic [5:0]        w_id_op;
  logic [4:0]        w_id_rs;
  logic [4:0]        w_id_rt;
  logic              w_reads_rt;
  logic              w_hold;
  logic              w_flush;
  logic              w_load_use;
  logic              w_unused;

  control_decoder u_dec (
    .Instr (Instr_ID),
    .Ctrl  (w_dec_bits)
  );

  assign w_dec    = ctrl_t'(w_dec_bits);
  assign w_id_op  = Instr_ID[31:26];
  assign w_id_rs  = Instr_ID[25:21];
  assign w_id_rt  = Instr_ID[20:16];
  assign w_unused = ^Instr_ID[15:0];

  assign w_reads_rt = (w_id_op == OP_RTYPE) || (w_id_op == OP_BEQ) || (w_id_op == OP_BNE) ||
                      (w_id_op == OP_SW) || (w_id_op == OP_SH) || (w_id_op == OP_SB);

  // Only a multiply can occupy EX with a nonzero count, so holding first never
  // masks a branch or jump that still needs to resolve.
  assign w_hold     = (r_mul_cnt != '0);
  assign w_flush    = !w_hold && ((r_idex.branch && BranchTaken_EX) || r_idex.jump);
  assign w_load_use = !w_hold && !w_flush && r_idex.memread && (r_rt_ex != 5'd0) &&
                      ((r_rt_ex == w_id_rs) || ((r_rt_ex == w_id_rt) && w_reads_rt));

  assign PCWrite   = !(w_hold || w_load_use);
  assign IFIDWrite = !(w_hold || w_load_use);
  assign IFIDFlush = w_flush;
  assign MulBusy   = w_hold;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_idex    <= BUBBLE;
      r_rt_ex   <= 5'd0;
      r_mul_cnt <= '0;
    end else if (w_hold) begin
      r_mul_cnt <= r_mul_cnt - CNT_W'(1);
    end else if (w_flush || w_load_use) begin
      r_idex    <= BUBBLE;
      r_rt_ex   <= 5'd0;
      r_mul_cnt <= '0;
    end else begin
      r_idex    <= w_dec;
      r_rt_ex   <= w_id_rt;
      r_mul_cnt <= (w_dec.aluop == ALU_MUL) ? CNT_W'(MUL_CYCLES - 1) : '0;
    end
  end

  assign RegDst_EX       = r_idex.regdst;
  assign ALUSrc_EX       = r_idex.alusrc;
  assign MemToReg_EX     = r_idex.memtoreg;
  assign RegWrite_EX     = r_idex.regwrite;
  assign MemRead_EX      = r_idex.memread;
  assign MemWrite_EX     = r_idex.memwrite;
  assign Branch_EX       = r_idex.branch;
  assign Jump_EX         = r_idex.jump;
  assign JumpRegister_EX = r_idex.jumpreg;
  assign Link_EX         = r_idex.link;
  assign ALUOp_EX        = ALUOP_W'(r_idex.aluop);
  assign Rt_EX           = r_rt_ex;

endmodule
